mem_access_unit: RTL and testbench

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB register. It turns the EX/MEM outputs into a data-bus transaction: address, byte enables, lane-replicated store data, and sign- or zero-extended load data. It waits for a bus acknowledge with a watchdog. While an access is in flight it holds `out_stall` high, which the pipeline uses to deassert the EN inputs of upstream registers.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_lane_fmt.sv | 40 ++++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states, full-word byte enables.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory-stage controller (master) and the memory system (slave).
interface mem_access_unit_if;
   logic        out_req;
   logic        out_we;
   logic [31:0] out_addr;
   logic [31:0] out_wdata;
   logic [3:0]  out_be;
   logic [31:0] in_rdata;
   logic        in_ack;

   modport master (
      output out_req, out_we, out_addr, out_wdata, out_be,
      input  in_rdata, in_ack
   );

   modport slave (
      input  out_req, out_we, out_addr, out_wdata, out_be,
      output in_rdata, in_ack
   );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: byte enables, store-data replication, load lane select and extension.
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sext,
   input  logic [31:0] rb,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = 8'(rdata >> {lane, 3'b000});
      half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
      be        = BE_WORD;
      wdata     = rb;
      load_data = rdata;
      // Reserved size 2'b11 falls through to word behaviour.
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            wdata     = {4{rb[7:0]}};
            load_data = {{24{sext & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = 4'b0011 << {lane[1], 1'b0};
            wdata     = {2{rb[15:0]}};
            load_data = {{16{sext & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues one bus transaction per EX/MEM slot and stalls the pipe until done.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of force-aligning them.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 15
)
(
   input  logic               in_CLK,
   input  logic               in_CLR,
   input  logic               in_valid,
   input  logic               in_mem_rd,
   input  logic               in_mem_wr,
   input  logic [1:0]         in_size,
   input  logic               in_sext,
   input  logic [31:0]        in_R,
   input  logic [31:0]        in_rb,
   output logic [31:0]        out_rdata,
   output logic               out_stall,
   output logic               out_done,
   output logic               out_bus_err,
   output logic               out_align_err,
   mem_access_unit_if.master  bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic          request, align_fault;
   logic          latch, cap_load, clr_rdata, set_bus_err;
   logic [31:0]   addr_al;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic [3:0]    be_q;
   logic          we_q, bus_err_q;
   logic [3:0]    fmt_be;
   logic [31:0]   fmt_wdata, fmt_load;

   assign request = in_valid & (in_mem_rd | in_mem_wr);
   assign cnt_inc = cnt + CW'(1);

   always_comb begin
      addr_al = in_R;
      case (in_size)
         SZ_BYTE: ;
         SZ_HALF: addr_al[0]   = 1'b0;
         default: addr_al[1:0] = 2'b00;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      case (in_size)
         SZ_BYTE: align_fault = 1'b0;
         SZ_HALF: align_fault = in_R[0];
         default: align_fault = |in_R[1:0];
      endcase
   end
`else
   assign align_fault = 1'b0;
`endif

   mem_lane_fmt u_fmt (
      .size      (in_size),
      .lane      (addr_al[1:0]),
      .sext      (in_sext),
      .rb        (in_rb),
      .rdata     (bus.in_rdata),
      .be        (fmt_be),
      .wdata     (fmt_wdata),
      .load_data (fmt_load)
   );

   always_ff @(posedge in_CLK or posedge in_CLR) begin
      if (in_CLR) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      latch       = 1'b0;
      cap_load    = 1'b0;
      clr_rdata   = 1'b0;
      set_bus_err = 1'b0;
      case (state)
         ST_IDLE: begin
            if (request) begin
               if (align_fault) begin
                  state_n   = ST_DONE;
                  clr_rdata = 1'b1;
               end else begin
                  latch   = 1'b1;
                  cnt_n   = '0;
                  state_n = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // An acknowledge on the final watchdog cycle still wins over the abort.
            if (bus.in_ack) begin
               state_n  = ST_DONE;
               cap_load = ~we_q;
            end else begin
               cnt_n = cnt_inc;
               if (cnt_inc == CW'(TIMEOUT)) begin
                  state_n     = ST_DONE;
                  set_bus_err = 1'b1;
                  clr_rdata   = 1'b1;
               end
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_CLK or posedge in_CLR) begin
      if (in_CLR) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (latch) begin
            addr_q  <= addr_al;
            wdata_q <= fmt_wdata;
            be_q    <= fmt_be;
            we_q    <= in_mem_wr;
         end
         if (cap_load)
            rdata_q <= fmt_load;
         else if (clr_rdata)
            rdata_q <= '0;
         bus_err_q <= set_bus_err;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic align_err_q;

   always_ff @(posedge in_CLK or posedge in_CLR) begin
      if (in_CLR)
         align_err_q <= 1'b0;
      else
         align_err_q <= (state == ST_IDLE) & request & align_fault;
   end

   assign out_align_err = align_err_q;
`else
   assign out_align_err = 1'b0;
`endif

   assign bus.out_req   = (state == ST_WAIT);
   assign bus.out_we    = we_q;
   assign bus.out_addr  = addr_q;
   assign bus.out_wdata = wdata_q;
   assign bus.out_be    = be_q;

   assign out_rdata   = rdata_q;
   assign out_done    = (state == ST_DONE);
   assign out_bus_err = bus_err_q;
   // Released in DONE so EX/MEM advances on the edge that closes the access.
   assign out_stall   = ~in_CLR & (((state == ST_IDLE) & request) | (state == ST_WAIT));

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus random accesses against a byte-level reference model.
module tb_mem_access_unit;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_valid, in_mem_rd, in_mem_wr, in_sext;
   logic [1:0]  in_size;
   logic [31:0] in_R, in_rb;
   logic [31:0] out_rdata;
   logic        out_stall, out_done, out_bus_err, out_align_err;

   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
      .in_CLK        (clk),
      .in_CLR        (clr),
      .in_valid      (in_valid),
      .in_mem_rd     (in_mem_rd),
      .in_mem_wr     (in_mem_wr),
      .in_size       (in_size),
      .in_sext       (in_sext),
      .in_R          (in_R),
      .in_rb         (in_rb),
      .out_rdata     (out_rdata),
      .out_stall     (out_stall),
      .out_done      (out_done),
      .out_bus_err   (out_bus_err),
      .out_align_err (out_align_err),
      .bus           (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        bus_err;
      logic        align_err;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] model_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: bytes of access, natural alignment, little-endian lanes, plain shifts and masks.
   function automatic exp_t model(input logic wr, input logic [1:0] size, input logic sext,
                                  input logic [31:0] addr, input logic [31:0] rb,
                                  input logic [31:0] rdata, input int ack_at,
                                  input logic [31:0] prev);
      exp_t        e;
      int          nb, lane, t;
      logic [31:0] v, m;
      nb          = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      lane        = int'(addr[1:0]);
      e.addr      = '0;
      e.be        = '0;
      e.we        = 1'b0;
      e.wdata     = '0;
      e.rdata     = prev;
      e.bus_err   = 1'b0;
      e.align_err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if ((lane % nb) != 0) begin
         e.align_err = 1'b1;
         e.rdata     = '0;
         return e;
      end
`endif
      lane   = lane - (lane % nb);
      e.addr = {addr[31:2], 2'b00} + 32'(lane);
      t      = ((1 << nb) - 1) << lane;
      e.be   = t[3:0];
      e.we   = wr;
      for (int i = 0; i < 4; i++)
         e.wdata[8*i +: 8] = rb[8*(i % nb) +: 8];
      if (ack_at >= 1 && ack_at <= TIMEOUT) begin
         if (!wr) begin
            v = rdata >> (8 * lane);
            if (nb < 4) begin
               m = (32'h1 << (8 * nb)) - 32'h1;
               v = v & m;
               if (sext && v[8*nb-1]) v = v | ~m;
            end
            e.rdata = v;
         end
      end else begin
         e.bus_err = 1'b1;
         e.rdata   = '0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!clr && out_done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done with no access pending, expected none");
         end else begin
            mon_e = sb.pop_front();
            check("rdata", out_rdata, mon_e.rdata);
            check("bus_err", 32'(out_bus_err), 32'(mon_e.bus_err));
            check("align_err", 32'(out_align_err), 32'(mon_e.align_err));
            if (!mon_e.align_err) begin
               check("addr", bus.out_addr, mon_e.addr);
               check("be", 32'(bus.out_be), 32'(mon_e.be));
               check("we", 32'(bus.out_we), 32'(mon_e.we));
               check("wdata", bus.out_wdata, mon_e.wdata);
            end
         end
      end else if (!clr) begin
         check("err_outside_done", 32'({out_bus_err, out_align_err}), 32'd0);
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] rb,
                         input logic [31:0] rdata, input int ack_at);
      exp_t e;
      int   done_at;
      bit   seen;
      e = model(wr, size, sext, addr, rb, rdata, ack_at, model_rdata);
      sb.push_back(e);
      model_rdata = e.rdata;
      done_at = e.align_err ? 1 : (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at + 1 : TIMEOUT + 1;
      @(negedge clk);
      in_valid     = 1'b1;
      in_mem_rd    = rd;
      in_mem_wr    = wr;
      in_size      = size;
      in_sext      = sext;
      in_R         = addr;
      in_rb        = rb;
      bus.in_rdata = rdata;
      bus.in_ack   = 1'b0;
      #1 check("stall_idle", 32'(out_stall), 32'd1);
      seen = 1'b0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         if (out_done) begin
            seen = 1'b1;
            check("latency", 32'(n), 32'(done_at));
            check("stall_done", 32'(out_stall), 32'd0);
            check("req_done", 32'(bus.out_req), 32'd0);
            in_valid   = 1'b0;
            bus.in_ack = 1'b0;
         end else begin
            check("stall_wait", 32'(out_stall), 32'd1);
            check("req_wait", 32'(bus.out_req), 32'd1);
            bus.in_ack = (n == ack_at);
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL no_done: got no done within 40 cycles, expected done at cycle %0d", done_at);
         in_valid   = 1'b0;
         bus.in_ack = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, 32'(bus.out_req), 32'd0);
      check({tag, "_we"}, 32'(bus.out_we), 32'd0);
      check({tag, "_addr"}, bus.out_addr, 32'd0);
      check({tag, "_wdata"}, bus.out_wdata, 32'd0);
      check({tag, "_be"}, 32'(bus.out_be), 32'd0);
      check({tag, "_rdata"}, out_rdata, 32'd0);
      check({tag, "_stall"}, 32'(out_stall), 32'd0);
      check({tag, "_done"}, 32'(out_done), 32'd0);
      check({tag, "_errs"}, 32'({out_bus_err, out_align_err}), 32'd0);
   endtask

   initial begin
      int          r, ack;
      logic        rd, wr;
      logic [1:0]  op;
      clr          = 1'b1;
      in_valid     = 1'b1;
      in_mem_rd    = 1'b1;
      in_mem_wr    = 1'b0;
      in_size      = 2'b10;
      in_sext      = 1'b0;
      in_R         = 32'h100;
      in_rb        = '0;
      bus.in_rdata = '0;
      bus.in_ack   = 1'b0;
      #1 check_all_zero("reset");
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;

      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
      access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 1);
      access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 2);
      access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 1);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h12345678, 0);
      access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h9ABC0000, TIMEOUT);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 1);
      access(1'b1, 1'b1, 2'b11, 1'b0, 32'h208, 32'h55AA33CC, 32'h0, 3);

      // Reset in the second WAIT cycle of a load that would otherwise time out.
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0BADCAFE, 1);
      @(negedge clk);
      in_valid  = 1'b1;
      in_mem_rd = 1'b1;
      in_mem_wr = 1'b0;
      in_size   = 2'b10;
      in_R      = 32'h200;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      #1 check_all_zero("midreset");
      in_valid    = 1'b0;
      model_rdata = '0;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      access(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'hBEEF1234, 2);

      for (int i = 0; i < 60; i++) begin
         r   = $urandom_range(0, 9);
         ack = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 1 : $urandom_range(1, 4);
         op  = 2'($urandom_range(0, 2));
         rd  = (op != 2'd1);
         wr  = (op != 2'd0);
         access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, ack);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
